// File: rtl/mod32_accumulator.sv
//------------------------------------------------------------------------------
// mod32_accumulator : streaming multi-operand modulo-2^WIDTH adder with
//                     valid/ready input and output handshakes.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mod32_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry
);
    assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, i_b};
endmodule

module mod32_accumulator #(
    parameter int WIDTH   = 32,
    parameter int MAX_OPS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [7:0]       out_count,
    output logic             out_ovf,
    output logic             out_err
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [7:0] c_MAX_OPS = 8'(MAX_OPS);

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [7:0]       r_count;
    logic             r_ovf;
    logic             r_err;
    logic             r_in_ready;
    logic             r_out_valid;

    logic [WIDTH-1:0] w_sum;
    logic             w_carry;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic [7:0]       w_count_inc;

    mod32_adder #(.WIDTH(WIDTH)) u_adder (
        .i_a     (r_acc),
        .i_b     (in_data),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    assign w_in_xfer   = in_valid & r_in_ready;
    assign w_out_xfer  = r_out_valid & out_ready;
    assign w_count_inc = r_count + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_err       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_in_xfer) begin
                        r_acc   <= in_data;
                        r_count <= 8'd1;
                        r_ovf   <= 1'b0;
                        r_err   <= 1'b0;
                        if (in_last) begin
                            r_state     <= S_DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= S_ACCUM;
                        end
                    end
                end
                S_ACCUM: begin
                    if (w_in_xfer) begin
                        r_acc   <= w_sum;
                        r_ovf   <= r_ovf | w_carry;
                        r_count <= w_count_inc;
                        // Hitting the operand limit without in_last closes the sum early.
                        if (in_last || (w_count_inc == c_MAX_OPS)) begin
                            r_err       <= ~in_last;
                            r_state     <= S_DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (w_out_xfer) begin
                        r_state     <= S_IDLE;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_acc;
    assign out_count = r_count;
    assign out_ovf   = r_ovf;
    assign out_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mod32_accumulator.sv
//------------------------------------------------------------------------------
// tb_mod32_accumulator : randomized + directed self-checking bench against a
//                        queue-based arithmetic reference model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mod32_accumulator;
    localparam int WIDTH   = 32;
    localparam int MAX_OPS = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic [7:0]       out_count;
    logic             out_ovf;
    logic             out_err;

    mod32_accumulator #(.WIDTH(WIDTH), .MAX_OPS(MAX_OPS)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] s;
        logic [7:0]  c;
        logic        o;
        logic        e;
    } res_t;

    res_t        q[$];
    longint      m_acc;
    int          m_cnt;
    logic        m_ovf;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: plain arithmetic on the accepted operand sequence.
    task automatic model_push(input logic [31:0] d, input logic last);
        res_t r;
        if (m_cnt == 0) begin
            m_acc = d;
            m_ovf = 1'b0;
        end else begin
            m_acc = m_acc + longint'(d);
            if (m_acc >= 64'h1_0000_0000) begin
                m_ovf = 1'b1;
                m_acc = m_acc - 64'h1_0000_0000;
            end
        end
        m_cnt++;
        if (last || m_cnt == MAX_OPS) begin
            r.s = m_acc[31:0];
            r.c = 8'(m_cnt);
            r.o = m_ovf;
            r.e = !last;
            q.push_back(r);
            m_cnt = 0;
        end
    endtask

    task automatic send(input logic [31:0] d, input logic last, input int gap);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) check("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        model_push(d, last);
        in_valid = 1'b0;
        in_data  = $urandom;
        in_last  = $urandom_range(0, 1);
        repeat (gap) begin
            if (q.size() == 0) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic recv(input int hold);
        res_t r;
        if (q.size() == 0) begin
            check("model_empty", 32'd0, 32'd1);
            return;
        end
        r = q.pop_front();
        check("out_valid", 32'(out_valid), 32'd1);
        check("out_sum", out_sum, r.s);
        check("out_count", 32'(out_count), 32'(r.c));
        check("out_ovf", 32'(out_ovf), 32'(r.o));
        check("out_err", 32'(out_err), 32'(r.e));
        for (int i = 0; i < hold; i++) begin
            in_valid = $urandom_range(0, 1);
            in_data  = $urandom;
            @(posedge clk); #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_sum", out_sum, r.s);
            check("hold_count", 32'(out_count), 32'(r.c));
        end
        in_valid  = $urandom_range(0, 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("post_valid", 32'(out_valid), 32'd0);
        check("post_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic sendr(input logic [31:0] d, input logic last, input int gap, input int hold);
        send(d, last, gap);
        if (q.size() > 0) recv(hold);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b0;
        m_cnt = 0;
        q.delete();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        m_cnt = 0; m_acc = 0; m_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", out_sum, 32'd0);
        check("rst_count", 32'(out_count), 32'd0);
        check("rst_ovf", 32'(out_ovf), 32'd0);
        check("rst_err", 32'(out_err), 32'd0);

        // Pair sums with known answers
        sendr(32'ha0ced587, 1'b0, 0, 0);
        send(32'haca69a1b, 1'b1, 0);
        check("pair0_sum", out_sum, 32'h4d756fa2);
        recv(0);
        sendr(32'hd6f28b79, 1'b0, 0, 0); send(32'h449a9035, 1'b1, 0);
        check("pair1_sum", out_sum, 32'h1b8d1bae);
        recv(0);
        sendr(32'he2bb5641, 1'b0, 0, 0); send(32'h1e0049d5, 1'b1, 0);
        check("pair2_sum", out_sum, 32'h00bba016);
        recv(0);
        sendr(32'h04361d9c, 1'b0, 0, 0); send(32'h1023104d, 1'b1, 0);
        check("pair3_ovf", 32'(out_ovf), 32'd0);
        recv(0);

        // Four operands with idle gaps, then back-pressure
        sendr(32'ha0ced587, 1'b0, 2, 0);
        sendr(32'hd6f28b79, 1'b0, 2, 0);
        sendr(32'he2bb5641, 1'b0, 2, 0);
        send(32'h04361d9c, 1'b1, 0);
        check("four_sum", out_sum, 32'h5eb2d4dd);
        recv(5);

        // Forced termination at MAX_OPS; ninth operand opens a new sum
        for (int i = 0; i < 8; i++) sendr(32'h1, 1'b0, 0, 2);
        sendr(32'h1, 1'b0, 0, 0);
        send(32'h1, 1'b1, 0);
        check("after_max_count", 32'(out_count), 32'd2);
        recv(0);

        // Single operand and wrap
        sendr(32'hffffffff, 1'b1, 0, 0);
        sendr(32'hffffffff, 1'b0, 0, 0);
        send(32'h00000001, 1'b1, 0);
        check("wrap_sum", out_sum, 32'h0);
        recv(1);

        // Reset mid-sum discards it
        sendr(32'h11111111, 1'b0, 0, 0);
        sendr(32'h22222222, 1'b0, 0, 0);
        do_reset();
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        sendr(32'h5, 1'b0, 0, 0);
        send(32'h7, 1'b1, 0);
        check("rst_mid_sum", out_sum, 32'hc);
        recv(0);

        // Reset while a result is pending
        send(32'h12345678, 1'b1, 0);
        do_reset();
        check("rst_done_valid", 32'(out_valid), 32'd0);
        check("rst_done_ready", 32'(in_ready), 32'd1);

        // Randomized sums of random length, gaps and back-pressure
        for (int k = 0; k < 60; k++) begin
            int len = $urandom_range(1, 11);
            for (int j = 0; j < len; j++) begin
                logic [31:0] d;
                d = ($urandom_range(0, 3) == 0) ? 32'hffffffff : $urandom;
                sendr(d, (j == len - 1), $urandom_range(0, 2), $urandom_range(0, 3));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/mod32_accumulator.md
# mod32_accumulator

Streaming multi-operand modulo-2^32 adder for the SHA-256 datapath. It accepts a sequence of 32-bit operands over a valid/ready handshake, for example the terms of T1 = h + Σ1(e) + Ch(e,f,g) + K + W. It returns their wrapped sum, the operand count and an overflow flag on a second valid/ready handshake. It is the consuming end of the operand stream that drives the 32-bit adder: the adder is instantiated internally, and this block sequences and collects its results.

## Interface
- WIDTH, 32, operand and sum width; arithmetic is modulo 2^WIDTH.
- MAX_OPS, 8, maximum operands per sum (≥2, ≤255).

- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high, sampled on rising clk.
- in_valid  input  1  operand present on in_data.
- in_ready  output  1  block can accept an operand this cycle.
- in_data  input  WIDTH  operand.
- in_last  input  1  marks the final operand of the current sum.
- out_valid  output  1  result fields valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  WIDTH  sum of all operands mod 2^WIDTH.
- out_count  output  8  number of operands summed.
- out_ovf  output  1  at least one carry out of bit WIDTH-1 occurred.
- out_err  output  1  sum was force-terminated at MAX_OPS without in_last.

## Operation
- Transfer rules:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=1.
  - On input transfer: acc←in_data, count←1, ovf←0, err←0.
  - Next state is DONE if in_last, else ACCUM.
  - A single-operand sum is legal: out_sum=in_data, count=1.
- ACCUM:
  - in_ready=1.
  - On input transfer: acc←(acc+in_data)[WIDTH-1:0], ovf←ovf | carry-out, count←count+1.
  - Next state is DONE if in_last.
  - Next state is also DONE if count+1 == MAX_OPS with in_last=0; in that case err←1.
  - Operands after a forced termination belong to the next sum.
- DONE:
  - in_ready=0, out_valid=1.
  - out_sum, out_count, out_ovf and out_err equal the internal registers and stay stable until the output transfer.
  - On output transfer → IDLE.
  - No operand is accepted in the output-transfer cycle.
- in_valid low in ACCUM: state and accumulator hold; gaps between operands are allowed.
- in_data and in_last are ignored when no input transfer occurs.
- rst:
  - Forces IDLE and clears acc, count, ovf and err; in_ready=1 in the cycle after rst.
  - rst mid-sum (ACCUM) or with a pending result (DONE) discards that sum; no out_valid is produced for it.
- out_ready is ignored outside DONE.

## Timing
- Reset values: in_ready=1, out_valid=0, out_sum=0, out_count=0, out_ovf=0, out_err=0.
- The addition is combinational inside one cycle; the accumulator updates on the clk edge of the input transfer.
- Latency: if the last operand transfers at edge N, out_valid=1 from cycle N+1.
- Throughput: a k-operand sum occupies at least k+1 cycles (k accept cycles plus one DONE cycle with out_ready=1).
- Back-pressure: out_valid stays high and the outputs are frozen for as many cycles as out_ready is low.
- in_ready is a registered function of state only; it never depends combinationally on in_valid or out_ready.

## Test plan
- Pair sums with out_ready=1: run the four pairs below, each as two operands with in_last on the second.
  - a0ced587+aca69a1b → out_sum=4d756fa2, out_count=2, out_ovf=1.
  - d6f28b79+449a9035 → out_sum=1b8d1bae, out_ovf=1.
  - e2bb5641+1e0049d5 → out_sum=00bba016, out_ovf=1.
  - 04361d9c+1023104d → out_sum=14592de9, out_ovf=0.
  - Each result appears exactly one cycle after the last operand transfer.
- Four-operand stream with idle gaps: a0ced587, d6f28b79, e2bb5641, then 04361d9c with in_last, with in_valid low for 2 cycles between operands → out_sum=5eb2d4dd, out_count=4, out_ovf=1, out_err=0.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE.
  - Outputs remain constant and in_ready=0; in_valid pulses during this time are not accepted.
  - Raise out_ready → out_valid drops next cycle and in_ready=1.
- MAX_OPS overflow: feed nine operands of 00000001, none with in_last, under MAX_OPS=8.
  - After the 8th: out_sum=00000008, out_count=8, out_err=1, out_ovf=0.
  - The 9th operand starts a new sum, count=1.
- Single operand and wrap: ffffffff with in_last → out_sum=ffffffff, out_count=1. Then ffffffff, 00000001(last) → out_sum=00000000, out_ovf=1.
- Reset mid-operation:
  - Assert rst for one cycle after two operands of a four-operand sum → no out_valid; next sum 00000005+00000007(last) → 0000000c, count=2.
  - Assert rst while in DONE → out_valid=0 in the next cycle.
